// File: rtl/ramio_split.sv
// ramio_split: byte-addressable dual-port RAM, handshaked load/store port A with
// boundary-crossing accesses split into LO/HI word cycles, registered read-only port B.
module ramio_split #(
  parameter int ADDR_WIDTH = 13,
  parameter DATA_FILE = "",
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqA,
  input  logic [1:0]            weA,
  input  logic [2:0]            reA,
  input  logic [ADDR_WIDTH+1:0] addrA,
  input  logic [31:0]           dinA,
  output logic [31:0]           doutA,
  output logic                  readyA,
  output logic                  doneA,
  output logic                  errA,
  input  logic [ADDR_WIDTH+1:0] addrB,
  output logic [31:0]           doutB
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_q, f_w, w_hi, wr_addr;
  logic [1:0] off_q, sz_q, f_off, f_sz;
  logic sx_q, wr_q, f_wr, f_sx;
  logic [31:0] din_q, lo_q, f_din, wr_data, rd, ext;
  logic idle, one_op, crosses, err_c, acc, single, mem_we;
  logic [7:0] be8;
  logic [63:0] d64, r64;
  logic [3:0] wr_be;
  logic unused;
  assign unused = ^addrB[1:0];
  assign readyA = idle;
  // While split, the access fields come from the latched request instead of the live inputs.
  always_comb begin
    idle = state == IDLE;
    one_op = (weA != 2'b00) ^ (reA[1:0] != 2'b00);
    f_off = idle ? addrA[1:0] : off_q;
    f_sz = idle ? (weA != 2'b00 ? weA : reA[1:0]) : sz_q;
    f_w = idle ? addrA[ADDR_WIDTH+1:2] : w_q;
    f_din = idle ? dinA : din_q;
    f_wr = idle ? weA != 2'b00 : wr_q;
    f_sx = idle ? reA[2] : sx_q;
    crosses = (f_sz == 2'b10 && f_off == 2'b11) || (f_sz == 2'b11 && f_off != 2'b00);
    err_c = idle && reqA && (!one_op || (crosses && !MISALIGNED_EN));
    acc = idle && reqA && one_op && !(crosses && !MISALIGNED_EN);
    single = acc && !crosses;
    w_hi = f_w + ONE;
    be8 = (f_sz == 2'b01 ? 8'h01 : f_sz == 2'b10 ? 8'h03 : 8'h0f) << f_off;
    d64 = {32'b0, f_din} << {f_off, 3'b000};
    mem_we = f_wr && (single || !idle);
    wr_addr = state == HI ? w_hi : f_w;
    wr_be = state == HI ? be8[7:4] : be8[3:0];
    wr_data = state == HI ? d64[63:32] : d64[31:0];
    r64 = {state == HI ? mem[w_hi] : 32'b0, state == HI ? lo_q : mem[f_w]};
    rd = 32'(r64 >> {f_off, 3'b000});
    ext = f_sz == 2'b01 ? {{24{f_sx & rd[7]}}, rd[7:0]} :
          f_sz == 2'b10 ? {{16{f_sx & rd[15]}}, rd[15:0]} : rd;
  end
  always_comb state_nx = state == IDLE ? (acc && crosses ? LO : IDLE) : state == LO ? HI : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      doutA <= '0;
      doneA <= 1'b0;
      errA <= 1'b0;
      doutB <= '0;
      w_q <= '0;
      off_q <= '0;
      sz_q <= '0;
      sx_q <= 1'b0;
      wr_q <= 1'b0;
      din_q <= '0;
      lo_q <= '0;
    end else begin
      doneA <= single || state == HI;
      errA <= err_c;
      doutB <= mem[addrB[ADDR_WIDTH+1:2]];
      if ((single || state == HI) && !f_wr) doutA <= ext;
      if (idle) begin
        w_q <= addrA[ADDR_WIDTH+1:2];
        off_q <= addrA[1:0];
        sz_q <= f_sz;
        sx_q <= reA[2];
        wr_q <= weA != 2'b00;
        din_q <= dinA;
      end
      if (state == LO) lo_q <= mem[f_w];
    end
endmodule

// File: tb/tb_ramio_split.sv
// tb_ramio_split: directed vectors for ramio_split; u0 splits crossing accesses, u1 rejects them.
module tb_ramio_split;
  localparam int AW = 13;
  localparam int LAST = 4 * (1 << AW) - 1;
  logic clk = 1'b0, rst = 1'b0, reqA = 1'b0;
  logic [1:0] weA = '0;
  logic [2:0] reA = '0;
  logic [AW+1:0] addrA = '0, addrB = '0;
  logic [31:0] dinA = '0;
  logic [31:0] dout0, doutb0, dout1, doutb1;
  logic ready0, done0, err0, ready1, done1, err1;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [1:0] we;
    logic [2:0] re;
    int addr;
    logic [31:0] din;
    logic done;
    logic err;
    logic chk_d;
    logic [31:0] dout;
  } vec_t;
  vec_t tv [22];

  ramio_split #(.ADDR_WIDTH(AW), .MISALIGNED_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .reqA(reqA), .weA(weA), .reA(reA), .addrA(addrA), .dinA(dinA),
    .doutA(dout0), .readyA(ready0), .doneA(done0), .errA(err0), .addrB(addrB), .doutB(doutb0));
  ramio_split #(.ADDR_WIDTH(AW), .MISALIGNED_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .reqA(reqA), .weA(weA), .reA(reA), .addrA(addrA), .dinA(dinA),
    .doutA(dout1), .readyA(ready1), .doneA(done1), .errA(err1), .addrB(addrB), .doutB(doutb1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request for the edge T; returns at the falling edge after T.
  task automatic issue(input logic [1:0] we, input logic [2:0] re, input int addr, input logic [31:0] din);
    @(negedge clk);
    reqA = 1'b1; weA = we; reA = re; addrA = addr[AW+1:0]; dinA = din;
    @(negedge clk);
    reqA = 1'b0; weA = '0; reA = '0;
  endtask

  task automatic single(input string name, input logic [1:0] we, input logic [2:0] re, input int addr,
                        input logic [31:0] din, input logic chk_d, input logic [31:0] exp);
    issue(we, re, addr, din);
    chk({name, ".done"}, done0, 1'b1);
    if (chk_d) chk({name, ".dout"}, dout0, exp);
  endtask

  task automatic split(input string name, input logic [1:0] we, input logic [2:0] re, input int addr,
                       input logic [31:0] din, input logic chk_d, input logic [31:0] exp);
    issue(we, re, addr, din);
    chk({name, ".ready1"}, ready0, 1'b0);
    chk({name, ".done1"}, done0, 1'b0);
    @(negedge clk);
    chk({name, ".ready2"}, ready0, 1'b0);
    chk({name, ".done2"}, done0, 1'b0);
    @(negedge clk);
    chk({name, ".done3"}, done0, 1'b1);
    chk({name, ".ready3"}, ready0, 1'b1);
    if (chk_d) chk({name, ".dout"}, dout0, exp);
  endtask

  initial begin
    tv[0]  = '{2'd1, 3'd0, 0,  32'h12,       1'b1, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{2'd1, 3'd0, 1,  32'h34,       1'b1, 1'b0, 1'b0, 32'h0};
    tv[2]  = '{2'd1, 3'd0, 2,  32'h56,       1'b1, 1'b0, 1'b0, 32'h0};
    tv[3]  = '{2'd1, 3'd0, 3,  32'h78,       1'b1, 1'b0, 1'b0, 32'h0};
    tv[4]  = '{2'd0, 3'd3, 0,  32'h0,        1'b1, 1'b0, 1'b1, 32'h78563412};
    tv[5]  = '{2'd3, 3'd0, 8,  32'hFFFEFDFC, 1'b1, 1'b0, 1'b0, 32'h0};
    tv[6]  = '{2'd0, 3'd5, 8,  32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFC};
    tv[7]  = '{2'd0, 3'd5, 9,  32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFD};
    tv[8]  = '{2'd0, 3'd5, 10, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFE};
    tv[9]  = '{2'd0, 3'd5, 11, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    tv[10] = '{2'd0, 3'd6, 10, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFE};
    tv[11] = '{2'd0, 3'd2, 8,  32'h0,        1'b1, 1'b0, 1'b1, 32'h0000FDFC};
    tv[12] = '{2'd0, 3'd1, 9,  32'h0,        1'b1, 1'b0, 1'b1, 32'h000000FD};
    tv[13] = '{2'd0, 3'd5, 1,  32'h0,        1'b1, 1'b0, 1'b1, 32'h00000034};
    tv[14] = '{2'd0, 3'd6, 1,  32'h0,        1'b1, 1'b0, 1'b1, 32'h00005634};
    tv[15] = '{2'd0, 3'd2, 2,  32'h0,        1'b1, 1'b0, 1'b1, 32'h00007856};
    tv[16] = '{2'd3, 3'd7, 0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h00007856};
    tv[17] = '{2'd0, 3'd0, 0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h00007856};
    tv[18] = '{2'd0, 3'd3, 0,  32'h0,        1'b1, 1'b0, 1'b1, 32'h78563412};
    tv[19] = '{2'd0, 3'd7, 8,  32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFEFDFC};
    tv[20] = '{2'd2, 3'd0, 2,  32'h0000BEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    tv[21] = '{2'd0, 3'd3, 0,  32'h0,        1'b1, 1'b0, 1'b1, 32'hBEEF3412};

    repeat (3) @(negedge clk);
    chk("rst.dout", dout0, 32'h0);
    chk("rst.done", done0, 1'b0);
    chk("rst.err", err0, 1'b0);
    chk("rst.doutb", doutb0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.ready", ready0, 1'b1);
    chk("rst.done_after", done0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      issue(tv[i].we, tv[i].re, tv[i].addr, tv[i].din);
      chk($sformatf("v%0d.done", i), done0, tv[i].done);
      chk($sformatf("v%0d.err", i), err0, tv[i].err);
      chk($sformatf("v%0d.ready", i), ready0, 1'b1);
      if (tv[i].chk_d) chk($sformatf("v%0d.dout", i), dout0, tv[i].dout);
    end

    single("c_w1", 2'd3, 3'd0, 4, 32'h11223344, 1'b0, 32'h0);
    issue(2'd0, 3'd3, 0, 32'h0);
    chk("c_prev.dout1", dout1, 32'hBEEF3412);
    issue(2'd0, 3'd3, 1, 32'h0);
    chk("c_rd.err1", err1, 1'b1);
    chk("c_rd.done1", done1, 1'b0);
    chk("c_rd.dout1", dout1, 32'hBEEF3412);
    repeat (2) @(negedge clk);
    issue(2'd3, 3'd0, 5, 32'h0);
    chk("c_wr.err1", err1, 1'b1);
    repeat (2) @(negedge clk);
    issue(2'd0, 3'd3, 4, 32'h0);
    chk("c_mem.dout1", dout1, 32'h11223344);

    single("a_w1", 2'd3, 3'd0, 4, 32'h11223344, 1'b0, 32'h0);
    single("a_w2", 2'd3, 3'd0, 8, 32'h55667788, 1'b0, 32'h0);
    split("a_wr", 2'd3, 3'd0, 6, 32'hAABBCCDD, 1'b0, 32'h0);
    single("a_r1", 2'd0, 3'd3, 4, 32'h0, 1'b1, 32'hCCDD3344);
    single("a_r2", 2'd0, 3'd3, 8, 32'h0, 1'b1, 32'h5566AABB);
    split("a_rw", 2'd0, 3'd3, 6, 32'h0, 1'b1, 32'hAABBCCDD);
    split("a_rh", 2'd0, 3'd6, 7, 32'h0, 1'b1, 32'hFFFFBBCC);

    single("b_w1", 2'd1, 3'd0, LAST, 32'h80, 1'b0, 32'h0);
    single("b_w2", 2'd1, 3'd0, 0, 32'hFF, 1'b0, 32'h0);
    split("b_wrap", 2'd0, 3'd6, LAST, 32'h0, 1'b1, 32'hFFFFFF80);
    single("b_r0", 2'd0, 3'd3, 0, 32'h0, 1'b1, 32'hBEEF34FF);

    single("d_w", 2'd3, 3'd0, 16, 32'h22222222, 1'b0, 32'h0);
    addrB = 16;
    issue(2'd3, 3'd0, 16, 32'h11111111);
    chk("d.doutb_old", doutb0, 32'h22222222);
    @(negedge clk);
    chk("d.doutb_new", doutb0, 32'h11111111);
    chk("d.done_pulse", done0, 1'b0);

    single("e_w1", 2'd3, 3'd0, 4, 32'h11223344, 1'b0, 32'h0);
    single("e_w2", 2'd3, 3'd0, 8, 32'h55667788, 1'b0, 32'h0);
    issue(2'd3, 3'd0, 6, 32'hAABBCCDD);
    @(negedge clk);
    chk("e.in_hi", ready0, 1'b0);
    rst = 1'b0;
    #1;
    chk("e.ready_rst", ready0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    chk("e.done", done0, 1'b0);
    chk("e.dout", dout0, 32'h0);
    @(negedge clk);
    chk("e.ready", ready0, 1'b1);
    chk("e.done2", done0, 1'b0);
    single("e_r1", 2'd0, 3'd3, 4, 32'h0, 1'b1, 32'hCCDD3344);
    single("e_r2", 2'd0, 3'd3, 8, 32'h0, 1'b1, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
